piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in serial-out transmitter. It is the transmit end paired with the team's 4-bit `sipo` shift-register receiver.
- Accepts a WIDTH-bit word through a valid/ready handshake. Shifts the word out one bit per clock, with a frame-valid and a last-bit marker.
- `so` is intended to drive a `sipo` `si` input directly, for serial links and loopback tests.

Parameters:
- WIDTH, 4, word width in bits (≥2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first.
- IDLE_LEVEL, 0, value driven on `so` when no frame is active.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset. Asynchronous, active-low: asserted when 0.
- pi_valid  input  1  parallel word offered.
- pi  input  WIDTH  parallel word.
- pi_ready  output  1  transmitter can accept `pi` this cycle.
- so  output  1  serial data out.
- so_valid  output  1  `so` carries a frame bit this cycle.
- so_last  output  1  current bit is the final bit of the frame.
- busy  output  1  frame in progress.

Behaviour:
- Reset:
  - rst=0 immediately forces state IDLE, shift register 0, bit counter 0.
  - Outputs during reset: so=IDLE_LEVEL, so_valid=0, so_last=0, busy=0, pi_ready=0 (gated by rst).
  - pi_ready=1 in the first cycle after rst returns to 1.
  - Reset mid-frame aborts the frame. Remaining bits are discarded and nothing resumes.
- States: IDLE, SHIFT.
- IDLE:
  - pi_ready=1. On a clk edge with pi_valid&pi_ready: capture `pi`, set cnt=WIDTH-1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (cycle-level):
  - so = head bit of the shift register: MSB when MSB_FIRST, else LSB.
  - so_valid=1, busy=1, so_last=(cnt==0).
  - Each edge: shift the register one position toward the head, fill with 0, cnt-=1.
- Latency:
  - If a word is accepted at edge k, its first bit appears on `so` in the cycle after edge k.
  - Bit i (0-based, in transmit order) is presented in cycle k+1+i.
  - Frame occupies exactly WIDTH consecutive cycles with no gaps.
- Back-to-back:
  - pi_ready = IDLE | (SHIFT & cnt==0).
  - If pi_valid is high during the last-bit cycle, the new word loads at that edge. The next frame's first bit follows with zero idle cycles and state stays SHIFT.
  - Otherwise the FSM returns to IDLE after the last bit.
- pi_valid while pi_ready=0: ignored. `pi` changes during a frame do not affect the bits in flight. No input buffering beyond the shift register.
- Outputs are combinational from registered state only; there is no combinational path from pi/pi_valid to so.
- Counter width: $clog2(WIDTH). The counter never wraps: it is reloaded on acceptance.

Decomposition:
- Package piso_pkg:
  - state enum {ST_IDLE, ST_SHIFT}.
  - localparam function for counter width.
  - IDLE_LEVEL default constant.
- One sub-module, piso_bit_cnt: loadable down-counter with a zero flag, giving the cnt==0 / so_last decode. The FSM and shift register stay in piso_tx.

Test Plan:
1. Default params: hold rst=0 for 3 time units, release, pi=4'b1011, pi_valid=1 for one cycle -> so=1,0,1,1 on 4 consecutive cycles. so_valid high for those 4 cycles; so_last high only on the 4th; then so=0, pi_ready=1.
2. MSB_FIRST=0, pi=4'b1011 -> so=1,1,0,1; so_last on the 4th bit.
3. Back-to-back: 4'b1111 then 4'b0001, with pi_valid held high -> so=1,1,1,1,0,0,0,1 over 8 contiguous cycles. so_valid never drops; so_last pulses at cycles 4 and 8.
4. Mid-frame change: load 4'b1010, then drive pi=4'b0101 with pi_valid=1 during bits 1-3 -> serial stream stays 1,0,1,0. The new word loads only at the last-bit edge.
5. Reset mid-frame: assert rst=0 after 2 bits of 4'b1100 -> so=IDLE_LEVEL, so_valid=0 immediately, without waiting for clk. After release, no residual bits appear and pi_ready=1.
6. Loopback: connect so to the si input of a 4-bit `sipo` sharing clk; send 4'b1011 -> the sipo's po reads 4'b1011 on the cycle after so_last.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

  // Bits needed to hold WIDTH-1; never less than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Loadable down-counter tracking the bits remaining in the current frame.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_tx.sv
// Serialises WIDTH-bit words accepted via valid/ready, one bit per clock,
// with frame-valid and last-bit markers; back-to-back frames have no gap.
module piso_tx
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pi_valid,
  input  logic [WIDTH-1:0] pi,
  output logic             pi_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_last,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shift_d;
  logic             cnt_zero;
  logic             in_shift;
  logic             accept;
  logic             head;

  assign in_shift = (state_q == ST_SHIFT);
  // Ready is also masked by reset so nothing is handed over while held.
  assign pi_ready = rst & (~in_shift | cnt_zero);
  assign accept   = pi_valid & pi_ready;

  generate
    if (MSB_FIRST) begin : g_msb
      assign head    = shreg_q[WIDTH-1];
      assign shift_d = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign head    = shreg_q[0];
      assign shift_d = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  piso_bit_cnt #(
    .CW(CW)
  ) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (LOAD_VAL),
    .dec      (in_shift),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shreg_q <= pi;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (accept) begin
            shreg_q <= pi;
          end else begin
            shreg_q <= shift_d;
            if (cnt_zero) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          shreg_q <= '0;
        end
      endcase
    end
  end

  assign so       = in_shift ? head : IDLE_LEVEL;
  assign so_valid = in_shift;
  assign so_last  = in_shift & cnt_zero;
  assign busy     = in_shift;

endmodule

// File: tb/tb_piso_tx.sv
// Randomised and directed bench for piso_tx: MSB-first and LSB-first instances
// against a bit-queue reference model, plus a 4-bit shift receiver on loopback.
module tb_piso_tx;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         pi_valid;
  logic [W-1:0] pi;

  logic pi_ready_m, so_m, so_valid_m, so_last_m, busy_m;
  logic pi_ready_l, so_l, so_valid_l, so_last_l, busy_l;
  logic [W-1:0] rx_po;

  int checks;
  int failures;

  // Reference model: pending bits in transmit order, and words awaiting loopback.
  bit           q_m[$];
  bit           q_l[$];
  logic [W-1:0] wq[$];
  logic [W-1:0] exp_po;
  bit           po_chk;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .rst(rst), .pi_valid(pi_valid), .pi(pi),
    .pi_ready(pi_ready_m), .so(so_m), .so_valid(so_valid_m),
    .so_last(so_last_m), .busy(busy_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .rst(rst), .pi_valid(pi_valid), .pi(pi),
    .pi_ready(pi_ready_l), .so(so_l), .so_valid(so_valid_l),
    .so_last(so_last_l), .busy(busy_l)
  );

  // Plain 4-bit sipo receiver on the MSB-first link.
  always_ff @(posedge clk) begin
    rx_po <= {rx_po[W-2:0], so_m};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit nm, nl;
    nm = (q_m.size() > 0);
    nl = (q_l.size() > 0);
    check_eq("m_so_valid", so_valid_m, nm);
    check_eq("m_so",       so_m,       nm ? q_m[0] : 1'b0);
    check_eq("m_so_last",  so_last_m,  q_m.size() == 1);
    check_eq("m_busy",     busy_m,     nm);
    check_eq("m_pi_ready", pi_ready_m, q_m.size() <= 1);
    check_eq("l_so_valid", so_valid_l, nl);
    check_eq("l_so",       so_l,       nl ? q_l[0] : 1'b0);
    check_eq("l_so_last",  so_last_l,  q_l.size() == 1);
    check_eq("l_pi_ready", pi_ready_l, q_l.size() <= 1);
    if (po_chk) begin
      check_eq("loop_po", rx_po, exp_po);
      po_chk = 0;
    end
  endtask

  task automatic model_edge();
    bit ready;
    if (!rst) return;
    ready = (q_m.size() <= 1);
    if (q_m.size() > 0) begin
      if (q_m.size() == 1) begin
        exp_po = wq.pop_front();
        po_chk = 1;
      end
      void'(q_m.pop_front());
      void'(q_l.pop_front());
    end
    if (pi_valid && ready) begin
      for (int i = W - 1; i >= 0; i--) q_m.push_back(pi[i]);
      for (int i = 0; i < W; i++)      q_l.push_back(pi[i]);
      wq.push_back(pi);
      $display("TX word=%b t=%0t", pi, $time);
    end
  endtask

  // One cycle: check at the falling edge, drive new inputs, advance the model.
  task automatic step(input logic v, input logic [W-1:0] w);
    @(negedge clk);
    check_outputs();
    pi_valid = v;
    pi       = w;
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0);
  endtask

  task automatic reset_now();
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_so_valid", so_valid_m, 1'b0);
    check_eq("rst_so",       so_m,       1'b0);
    check_eq("rst_busy",     busy_m,     1'b0);
    check_eq("rst_pi_ready", pi_ready_m, 1'b0);
    check_eq("rst_l_valid",  so_valid_l, 1'b0);
    q_m.delete();
    q_l.delete();
    wq.delete();
    po_chk = 0;
    @(negedge clk);
    pi_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rel_pi_ready", pi_ready_m, 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    po_chk   = 0;
    exp_po   = '0;
    rst      = 1'b0;
    pi_valid = 1'b0;
    pi       = '0;
    #2;
    check_eq("init_so_valid", so_valid_m, 1'b0);
    check_eq("init_pi_ready", pi_ready_m, 1'b0);
    check_eq("init_busy",     busy_l,     1'b0);
    #1;
    rst = 1'b1;

    // Single frame, both bit orders, with loopback capture.
    step(1'b1, 4'b1011);
    idle(6);

    // Back-to-back frames with valid held high.
    step(1'b1, 4'b1111);
    for (int i = 0; i < W; i++) step(1'b1, 4'b0001);
    idle(6);

    // Input changes mid-frame must not disturb bits in flight.
    step(1'b1, 4'b1010);
    for (int i = 0; i < W; i++) step(1'b1, 4'b0101);
    idle(6);

    // Reset after two bits of a frame.
    step(1'b1, 4'b1100);
    idle(2);
    reset_now();
    idle(6);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), 4'($urandom));
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
